control_unit: RTL and testbench

//  Multi-cycle sequencer for the 10-bit datapath. Latches an instruction word on an EXEC

---
 rtl/control_unit.sv | 174 +++++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle sequencer for the 10-bit datapath (optional ILLEGAL_OP_TRAP_EN)
module control_unit #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
) (
  input  logic              CLKb,
  input  logic              RSTb,
  input  logic              EXEC,
  input  logic [DATA_W-1:0] INSTR,
  output logic              ENW,
  output logic              ENR0,
  output logic              ENR1,
  output logic [ADDR_W-1:0] WRA,
  output logic [ADDR_W-1:0] RDA0,
  output logic [ADDR_W-1:0] RDA1,
  output logic              AIN,
  output logic              GIN,
  output logic [2:0]        ALU_OP,
  output logic              B_SEL,
  output logic [1:0]        BUS_SEL,
  output logic              BUSY,
  output logic              DONE
`ifdef ILLEGAL_OP_TRAP_EN
  , output logic            ERR
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TRAP = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_COPY = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_SUBI = 4'd9;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              exec_q;
  logic              start;

  logic [3:0]        op;
  logic [ADDR_W-1:0] rx, ry;
  logic              unused_rsvd;

  assign op          = ir_q[9:6];
  assign rx          = ir_q[5:4];
  assign ry          = ir_q[3:2];
  assign unused_rsvd = ^ir_q[1:0];

  // A start needs a fresh rising edge of EXEC seen while idle; edges during BUSY are dropped
  assign start = (state_q == IDLE) && EXEC && !exec_q;
  assign ir_d  = start ? INSTR : ir_q;

  // State, instruction register and EXEC edge-detector registers
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      ir_q    <= '0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      exec_q  <= EXEC;
    end
  end

  // Next-state and control decode from current state and latched instruction only
  always_comb begin
    state_d = state_q;
    ENW     = 1'b0;
    ENR0    = 1'b0;
    ENR1    = 1'b0;
    WRA     = '0;
    RDA0    = '0;
    RDA1    = '0;
    AIN     = 1'b0;
    GIN     = 1'b0;
    ALU_OP  = 3'd0;
    B_SEL   = 1'b0;
    BUS_SEL = 2'd0;
    DONE    = 1'b0;
    BUSY    = (state_q != IDLE);
`ifdef ILLEGAL_OP_TRAP_EN
    ERR     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = T1;
      end
      T1: begin
        case (op)
          OP_LOAD: begin
            BUS_SEL = 2'd0;
            ENW     = 1'b1;
            WRA     = rx;
            DONE    = 1'b1;
            state_d = IDLE;
          end
          OP_COPY: begin
            ENR0    = 1'b1;
            RDA0    = ry;
            BUS_SEL = 2'd1;
            ENW     = 1'b1;
            WRA     = rx;
            DONE    = 1'b1;
            state_d = IDLE;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDI, OP_SUBI: begin
            ENR0    = 1'b1;
            RDA0    = rx;
            AIN     = 1'b1;
            state_d = T2;
          end
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = TRAP;
`else
            DONE    = 1'b1;
            state_d = IDLE;
`endif
          end
        endcase
      end
      T2: begin
        GIN     = 1'b1;
        state_d = T3;
        case (op)
          OP_ADD:  ALU_OP = 3'd0;
          OP_SUB:  ALU_OP = 3'd1;
          OP_AND:  ALU_OP = 3'd2;
          OP_OR:   ALU_OP = 3'd3;
          OP_XOR:  ALU_OP = 3'd4;
          OP_NOT:  ALU_OP = 3'd5;
          OP_ADDI: ALU_OP = 3'd0;
          OP_SUBI: ALU_OP = 3'd1;
          default: ALU_OP = 3'd0;
        endcase
        if (op == OP_ADDI || op == OP_SUBI) begin
          B_SEL = 1'b1;
        end else if (op != OP_NOT) begin
          ENR1 = 1'b1;
          RDA1 = ry;
        end
      end
      T3: begin
        BUS_SEL = 2'd2;
        ENW     = 1'b1;
        WRA     = rx;
        DONE    = 1'b1;
        state_d = IDLE;
      end
      TRAP: begin
        // Held until reset; never writes
`ifdef ILLEGAL_OP_TRAP_EN
        ERR     = 1'b1;
`endif
        state_d = TRAP;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench for control_unit with a small register-file/ALU model
module tb_control_unit;

  logic       CLKb, RSTb, EXEC;
  logic [9:0] INSTR;
  logic       ENW, ENR0, ENR1, AIN, GIN, B_SEL, BUSY, DONE;
  logic [1:0] WRA, RDA0, RDA1, BUS_SEL;
  logic [2:0] ALU_OP;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       ERR;
`endif

  control_unit #(.DATA_W(10), .ADDR_W(2)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .EXEC(EXEC), .INSTR(INSTR),
    .ENW(ENW), .ENR0(ENR0), .ENR1(ENR1), .WRA(WRA), .RDA0(RDA0), .RDA1(RDA1),
    .AIN(AIN), .GIN(GIN), .ALU_OP(ALU_OP), .B_SEL(B_SEL), .BUS_SEL(BUS_SEL),
    .BUSY(BUSY), .DONE(DONE)
`ifdef ILLEGAL_OP_TRAP_EN
    , .ERR(ERR)
`endif
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  int n_checks = 0;
  int n_fail   = 0;

  // datapath model driven by the controller outputs; registers written on negedge
  logic [9:0] regs [4];
  logic [9:0] a_q, g_q, ext_data;
  logic [9:0] q0, q1, b_op, bus;

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = '0;
    a_q = '0;
    g_q = '0;
  end

  always_comb begin
    q0   = ENR0 ? regs[RDA0] : 10'd0;
    q1   = ENR1 ? regs[RDA1] : 10'd0;
    b_op = B_SEL ? {6'd0, INSTR[3:0]} : q1;
    case (BUS_SEL)
      2'd0: bus = ext_data;
      2'd1: bus = q0;
      2'd2: bus = g_q;
      default: bus = {6'd0, INSTR[3:0]};
    endcase
  end

  function automatic logic [9:0] alu(input logic [2:0] f, input logic [9:0] a, input logic [9:0] b);
    case (f)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = ~a;
      default: alu = b;
    endcase
  endfunction

  always @(negedge CLKb) begin
    if (AIN) a_q <= q0;
    if (GIN) g_q <= alu(ALU_OP, a_q, b_op);
    if (ENW) regs[WRA] <= bus;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  // raises EXEC and returns one cycle later, in T1; EXEC left high
  task automatic start(input logic [9:0] i);
    INSTR = i;
    EXEC  = 1'b1;
    tick();
  endtask

  task automatic load(input logic [1:0] rx, input logic [9:0] val);
    ext_data = val;
    start({4'd0, rx, 4'd0});
    EXEC = 1'b0;
    tick();
  endtask

  function automatic logic [18:0] outs();
    outs = {ENW, ENR0, ENR1, WRA, RDA0, RDA1, AIN, GIN, ALU_OP, B_SEL, BUS_SEL, BUSY, DONE};
  endfunction

  int dones;

  initial begin
    RSTb = 1'b0; EXEC = 1'b0; INSTR = '0; ext_data = '0;
    repeat (2) @(posedge CLKb);
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    RSTb = 1'b1;
    tick();

    // LOAD R2 from external data
    ext_data = 10'h155;
    start(10'b0000_10_0000);
    check("load_enw", ENW, 1);
    check("load_wra", WRA, 2);
    check("load_bus", BUS_SEL, 0);
    check("load_done", DONE, 1);
    check("load_busy", BUSY, 1);
    EXEC = 1'b0;
    tick();
    check("load_idle_busy", BUSY, 0);
    check("load_idle_enw", ENW, 0);
    check("load_r2", regs[2], 10'h155);

    load(2'd1, 10'h200);
    load(2'd3, 10'h250);

    // ADD R1,R3 with an EXEC edge in T2 and EXEC then held high
    start(10'b0010_01_1100);
    check("add_t1_enr0", ENR0, 1);
    check("add_t1_rda0", RDA0, 1);
    check("add_t1_ain", AIN, 1);
    check("add_t1_enw", ENW, 0);
    EXEC = 1'b0;
    tick();
    check("add_t2_enr1", ENR1, 1);
    check("add_t2_rda1", RDA1, 3);
    check("add_t2_op", ALU_OP, 0);
    check("add_t2_gin", GIN, 1);
    check("add_t2_bsel", B_SEL, 0);
    EXEC = 1'b1;
    tick();
    check("add_t3_enw", ENW, 1);
    check("add_t3_wra", WRA, 1);
    check("add_t3_bus", BUS_SEL, 2);
    dones = DONE ? 1 : 0;
    repeat (10) begin
      tick();
      if (DONE) dones++;
    end
    check("add_single_done", dones, 1);
    check("add_r1_wrap", regs[1], 10'h050);
    EXEC = 1'b0;
    tick();

    // SUBI R0,#5 : 0 - 5 wraps to 0x3FB
    start(10'b1001_00_0101);
    EXEC = 1'b0;
    tick();
    check("subi_bsel", B_SEL, 1);
    check("subi_op", ALU_OP, 1);
    check("subi_enr1", ENR1, 0);
    tick();
    check("subi_wra", WRA, 0);
    check("subi_done", DONE, 1);
    tick();
    check("subi_r0", regs[0], 10'h3FB);

    // NOT R2
    start(10'b0111_10_0000);
    EXEC = 1'b0;
    tick();
    check("not_op", ALU_OP, 5);
    check("not_enr1", ENR1, 0);
    tick();
    tick();
    check("not_r2", regs[2], 10'h2AA);

    // COPY R3 <- R2
    start(10'b0001_11_1000);
    EXEC = 1'b0;
    check("copy_vec", 32'(outs()), 32'({1'b1, 1'b1, 1'b0, 2'd3, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, 1'b1, 1'b1}));
    tick();
    check("copy_r3", regs[3], 10'h2AA);

    // ADD R1,R3 aborted by reset in T2
    start(10'b0010_01_1100);
    EXEC = 1'b0;
    tick();
    RSTb = 1'b0;
    #1;
    check("rst_t2_outs", 32'(outs()), 32'd0);
    tick();
    RSTb = 1'b1;
    tick();
    check("rst_release_busy", BUSY, 0);
    check("rst_r1_kept", regs[1], 10'h050);

    // undefined opcode 15
    start(10'b1111_00_0000);
    EXEC = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    check("ill_t1_enw", ENW, 0);
    repeat (5) tick();
    check("ill_err", ERR, 1);
    check("ill_busy", BUSY, 1);
    check("ill_enw", ENW, 0);
    RSTb = 1'b0;
    #1;
    check("ill_rst_err", ERR, 0);
    tick();
    RSTb = 1'b1;
    tick();
    check("ill_rst_busy", BUSY, 0);
`else
    check("ill_done", DONE, 1);
    check("ill_enw", ENW, 0);
    tick();
    check("ill_idle", BUSY, 0);
`endif
    check("ill_regs_kept", regs[0], 10'h3FB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
